// File: rtl/risc_toy_pkg.sv
// Opcode map, FSM state encoding and write-back select codes for the RISC_TOY control path.
// The HALT state exists only when RISC_TOY_ILL_TRAP_EN is defined.
package risc_toy_pkg;

  localparam logic [4:0] OP_ADDI = 5'd0;
  localparam logic [4:0] OP_ANDI = 5'd1;
  localparam logic [4:0] OP_ORI  = 5'd2;
  localparam logic [4:0] OP_MOVI = 5'd3;
  localparam logic [4:0] OP_ADD  = 5'd4;
  localparam logic [4:0] OP_SUB  = 5'd5;
  localparam logic [4:0] OP_NEG  = 5'd6;
  localparam logic [4:0] OP_NOT  = 5'd7;
  localparam logic [4:0] OP_AND  = 5'd8;
  localparam logic [4:0] OP_OR   = 5'd9;
  localparam logic [4:0] OP_XOR  = 5'd10;
  localparam logic [4:0] OP_LSR  = 5'd11;
  localparam logic [4:0] OP_ASR  = 5'd12;
  localparam logic [4:0] OP_SHL  = 5'd13;
  localparam logic [4:0] OP_ROR  = 5'd14;
  localparam logic [4:0] OP_BR   = 5'd15;
  localparam logic [4:0] OP_BRL  = 5'd16;
  localparam logic [4:0] OP_J    = 5'd17;
  localparam logic [4:0] OP_JL   = 5'd18;
  localparam logic [4:0] OP_LD   = 5'd19;
  localparam logic [4:0] OP_ST   = 5'd20;
  localparam logic [4:0] OP_LDR  = 5'd21;
  localparam logic [4:0] OP_STR  = 5'd22;

  localparam logic [1:0] WB_ALU  = 2'd0;
  localparam logic [1:0] WB_MEM  = 2'd1;
  localparam logic [1:0] WB_LINK = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5
`ifdef RISC_TOY_ILL_TRAP_EN
    , S_HALT = 3'd6
`endif
  } state_t;

  typedef enum logic [2:0] {
    C_ALU, C_BR, C_BRL, C_J, C_JL, C_LOAD, C_STORE, C_ILL
  } op_class_t;

  function automatic op_class_t op_class(input logic [4:0] op);
    op_class_t c;
    if (op >= OP_ADDI && op <= OP_ROR) begin
      c = C_ALU;
    end else begin
      case (op)
        OP_BR:          c = C_BR;
        OP_BRL:         c = C_BRL;
        OP_J:           c = C_J;
        OP_JL:          c = C_JL;
        OP_LD, OP_LDR:  c = C_LOAD;
        OP_ST, OP_STR:  c = C_STORE;
        default:        c = C_ILL;
      endcase
    end
    return c;
  endfunction

endpackage

// File: rtl/risc_toy_wait_cnt.sv
// Memory-latency wait counter shared by FETCH and MEM: reloads to MEM_LAT-1, counts down,
// stops at zero; 'last' marks the final held cycle of a request.
module risc_toy_wait_cnt
#(
  parameter int MEM_LAT = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic last
);

  localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [CW-1:0] TOP = CW'(MEM_LAT - 1);

  logic [CW-1:0] rem;

  always_ff @(posedge clk) begin
    if (rst || load) begin
      rem <= TOP;
    end else if (rem != '0) begin
      rem <= rem - CW'(1);
    end
  end

  assign last = (rem == '0);

endmodule

// File: rtl/risc_toy_ctrl_fsm.sv
// Multi-cycle IDLE/FETCH/DECODE/EXEC/MEM/WB sequencer for RISC_TOY; outputs are decoded from state, wait counter and captured opcode.
// RISC_TOY_ILL_TRAP_EN: opcodes 23-31 park the FSM in HALT with trap held, instead of retiring as NOPs.
module risc_toy_ctrl_fsm
  import risc_toy_pkg::*;
#(
  parameter int MEM_LAT = 1,
  parameter int OPW     = 5
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic           run,
  input  logic [OPW-1:0] opcode,
  input  logic           cond_true,
  output logic           ireq,
  output logic           ir_load,
  output logic           pc_inc,
  output logic           pc_load,
  output logic           dreq,
  output logic           drw,
  output logic           rf_wen,
  output logic [1:0]     wb_sel,
  output logic           instr_done,
  output logic           trap
);

`ifdef RISC_TOY_ILL_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  state_t         state;
  state_t         retire_to;
  logic [OPW-1:0] ir_op;
  op_class_t      cls;
  logic           waiting;
  logic           last;
  logic           cnt_load;

  assign cls       = op_class(ir_op[4:0]);
  assign retire_to = run ? S_FETCH : S_IDLE;
  assign waiting   = (state == S_FETCH) || (state == S_MEM);
  // Reloading whenever no request is in flight keeps the count at MEM_LAT-1 on entry to FETCH/MEM.
  assign cnt_load  = !waiting || last;

  risc_toy_wait_cnt #(.MEM_LAT(MEM_LAT)) u_wait_cnt (
    .clk  (CLK),
    .rst  (RST),
    .load (cnt_load),
    .last (last)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= S_IDLE;
      ir_op <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (run) state <= S_FETCH;
        end
        S_FETCH: begin
          if (last) begin
            ir_op <= opcode;
            state <= S_DECODE;
          end
        end
        S_DECODE: state <= S_EXEC;
        S_EXEC: begin
          case (cls)
            C_ALU, C_JL:      state <= S_WB;
            C_LOAD, C_STORE:  state <= S_MEM;
            C_BRL:            state <= cond_true ? S_WB : retire_to;
            C_BR, C_J:        state <= retire_to;
            default: begin
`ifdef RISC_TOY_ILL_TRAP_EN
              state <= S_HALT;
`else
              state <= retire_to;
`endif
            end
          endcase
        end
        S_MEM: begin
          if (last) state <= (cls == C_LOAD) ? S_WB : retire_to;
        end
        S_WB: state <= retire_to;
`ifdef RISC_TOY_ILL_TRAP_EN
        S_HALT: state <= S_HALT;
`endif
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    ireq       = 1'b0;
    ir_load    = 1'b0;
    pc_inc     = 1'b0;
    pc_load    = 1'b0;
    dreq       = 1'b0;
    drw        = 1'b0;
    rf_wen     = 1'b0;
    wb_sel     = WB_ALU;
    instr_done = 1'b0;
    case (state)
      S_FETCH: begin
        ireq    = 1'b1;
        ir_load = last;
        pc_inc  = last;
      end
      S_EXEC: begin
        case (cls)
          C_BR: begin
            pc_load    = cond_true;
            instr_done = 1'b1;
          end
          C_BRL: begin
            pc_load    = cond_true;
            instr_done = !cond_true;
          end
          C_J: begin
            pc_load    = 1'b1;
            instr_done = 1'b1;
          end
          C_JL:    pc_load    = 1'b1;
          C_ILL:   instr_done = !TRAP_EN;
          default: ;
        endcase
      end
      S_MEM: begin
        dreq       = 1'b1;
        drw        = (cls == C_STORE);
        instr_done = last && (cls == C_STORE);
      end
      S_WB: begin
        rf_wen     = 1'b1;
        instr_done = 1'b1;
        if (cls == C_LOAD)     wb_sel = WB_MEM;
        else if (cls == C_ALU) wb_sel = WB_ALU;
        else                   wb_sel = WB_LINK;
      end
      default: ;
    endcase
  end

`ifdef RISC_TOY_ILL_TRAP_EN
  assign trap = (state == S_HALT);
`else
  assign trap = 1'b0;
`endif

endmodule

// File: tb/tb_risc_toy_ctrl_fsm.sv
// Directed and randomized check of risc_toy_ctrl_fsm at MEM_LAT=1 and MEM_LAT=2 against a per-instruction
// cycle-trace model built from the opcode class rules.
module tb_risc_toy_ctrl_fsm;

  typedef struct packed {
    logic       ireq;
    logic       ir_load;
    logic       pc_inc;
    logic       pc_load;
    logic       dreq;
    logic       drw;
    logic       rf_wen;
    logic [1:0] wb_sel;
    logic       done;
    logic       trap;
  } vec_t;

`ifdef RISC_TOY_ILL_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_s  [2];
  logic       run_s  [2];
  logic       cond_s [2];
  logic [4:0] op_s   [2];
  logic       ireq_o [2], irl_o [2], pci_o [2], pcl_o [2], dreq_o [2], drw_o [2], rfw_o [2], done_o [2], trap_o [2];
  logic [1:0] wb_o   [2];
  vec_t       obs    [2];
  vec_t       exp_v  [2];
  bit         chk    [2];
  bit         idle   [2];
  int         tests;
  int         fails;
  vec_t       seq[$];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    risc_toy_ctrl_fsm #(.MEM_LAT(g == 0 ? 1 : 2), .OPW(5)) dut (
      .CLK        (clk),
      .RST        (rst_s[g]),
      .run        (run_s[g]),
      .opcode     (op_s[g]),
      .cond_true  (cond_s[g]),
      .ireq       (ireq_o[g]),
      .ir_load    (irl_o[g]),
      .pc_inc     (pci_o[g]),
      .pc_load    (pcl_o[g]),
      .dreq       (dreq_o[g]),
      .drw        (drw_o[g]),
      .rf_wen     (rfw_o[g]),
      .wb_sel     (wb_o[g]),
      .instr_done (done_o[g]),
      .trap       (trap_o[g])
    );
    assign obs[g] = {ireq_o[g], irl_o[g], pci_o[g], pcl_o[g], dreq_o[g], drw_o[g],
                     rfw_o[g], wb_o[g], done_o[g], trap_o[g]};
  end

  function automatic int lat_of(input int d);
    return (d == 0) ? 1 : 2;
  endfunction

  // Expected per-cycle outputs for one instruction, from FETCH through its retire (or HALT entry).
  task automatic build_seq(input int lat, input int op, input bit cond);
    vec_t v;
    bit alu, br, brl, j, jl, ld, st, ill, to_mem, to_wb;
    alu = (op <= 14);
    br  = (op == 15);
    brl = (op == 16);
    j   = (op == 17);
    jl  = (op == 18);
    ld  = (op == 19) || (op == 21);
    st  = (op == 20) || (op == 22);
    ill = (op >= 23);
    to_mem = ld || st;
    to_wb  = alu || jl || (brl && cond);
    seq.delete();
    for (int i = 0; i < lat; i++) begin
      v = '0;
      v.ireq    = 1'b1;
      v.ir_load = (i == lat - 1);
      v.pc_inc  = (i == lat - 1);
      seq.push_back(v);
    end
    v = '0;
    seq.push_back(v);
    v = '0;
    v.pc_load = j || jl || ((br || brl) && cond);
    v.done    = !to_mem && !to_wb && !(ill && TRAP_EN);
    seq.push_back(v);
    if (to_mem) begin
      for (int i = 0; i < lat; i++) begin
        v = '0;
        v.dreq = 1'b1;
        v.drw  = st;
        v.done = st && (i == lat - 1);
        seq.push_back(v);
      end
    end
    if (ld || to_wb) begin
      v = '0;
      v.rf_wen = 1'b1;
      v.wb_sel = ld ? 2'd1 : (alu ? 2'd0 : 2'd2);
      v.done   = 1'b1;
      seq.push_back(v);
    end
  endtask

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (chk[d]) begin
        tests++;
        if (obs[d] !== exp_v[d]) begin
          fails++;
          $display("FAIL trace dut%0d t=%0t: got %b expected %b (ireq,irl,pci,pcl,dreq,drw,rfw,wb2,done,trap)",
                   d, $time, obs[d], exp_v[d]);
        end
        tests++;
        if ($countones({obs[d].ireq, obs[d].dreq, obs[d].rf_wen}) > 1) begin
          fails++;
          $display("FAIL strobe_excl dut%0d t=%0t: ireq/dreq/rf_wen=%b%b%b expected at most one",
                   d, $time, obs[d].ireq, obs[d].dreq, obs[d].rf_wen);
        end
      end
    end
  end

  task automatic pin_vec(input string nm, input vec_t got, input vec_t want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %b expected %b", nm, got, want);
    end
  endtask

  task automatic pin_int(input string nm, input int got, input int want);
    tests++;
    if (got != want) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, got, want);
    end
  endtask

  task automatic drive(input int d, input bit rs, input bit r, input logic [4:0] o, input bit c,
                       input vec_t e, input bit ck);
    rst_s[d]  = rs;
    run_s[d]  = r;
    op_s[d]   = o;
    cond_s[d] = c;
    exp_v[d]  = e;
    chk[d]    = ck;
    @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic after_reset(input int d);
    drive(d, 1'b0, 1'b0, 5'($urandom), 1'($urandom), '0, 1'b1);
    drive(d, 1'b0, 1'b0, 5'($urandom), 1'($urandom), '0, 1'b1);
    idle[d] = 1'b1;
  endtask

  task automatic reset_dut(input int d);
    drive(d, 1'b1, 1'b0, 5'($urandom), 1'($urandom), '0, 1'b0);
    after_reset(d);
  endtask

  task automatic ensure_run(input int d);
    bit r;
    for (int k = 0; k < 5 && idle[d]; k++) begin
      r = (k == 4) ? 1'b1 : 1'($urandom_range(0, 1));
      drive(d, 1'b0, r, 5'($urandom), 1'($urandom), '0, 1'b1);
      if (r) idle[d] = 1'b0;
    end
  endtask

  // ab: -1 no reset, -2 reset at a random cycle, otherwise reset asserted in cycle ab of the trace.
  task automatic do_instr(input int d, input int op, input bit cond, input bit run_after, input int ab);
    int lat, abort_at, n;
    logic [4:0] o;
    bit c, r;
    vec_t h;
    ensure_run(d);
    lat = lat_of(d);
    build_seq(lat, op, cond);
    n = seq.size();
    abort_at = (ab == -2) ? int'($urandom_range(0, n - 1)) : ab;
    for (int i = 0; i < n; i++) begin
      o = (i == lat - 1) ? 5'(op) : 5'($urandom);
      c = (i == lat + 1) ? cond : 1'($urandom);
      r = (i == n - 1) ? run_after : ($urandom_range(0, 3) != 0);
      if (i == abort_at) begin
        drive(d, 1'b1, r, o, c, seq[i], 1'b1);
        after_reset(d);
        return;
      end
      drive(d, 1'b0, r, o, c, seq[i], 1'b1);
    end
`ifdef RISC_TOY_ILL_TRAP_EN
    if (op >= 23) begin
      h = '0;
      h.trap = 1'b1;
      for (int k = 0; k < 3; k++) drive(d, 1'b0, 1'($urandom), 5'($urandom), 1'($urandom), h, 1'b1);
      reset_dut(d);
      return;
    end
`else
    h = '0;
`endif
    idle[d] = !run_after;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    for (int d = 0; d < 2; d++) begin
      rst_s[d] = 1'b1; run_s[d] = 1'b0; op_s[d] = '0; cond_s[d] = 1'b0;
      chk[d] = 1'b0; idle[d] = 1'b1; exp_v[d] = '0;
    end
    @(posedge clk);
    #1;

    build_seq(1, 4, 1'b0);
    pin_int("model_add_l1_len", seq.size(), 4);
    pin_vec("model_add_l1_fetch", seq[0], 11'b11100000000);
    pin_vec("model_add_l1_wb", seq[3], 11'b00000010010);
    build_seq(2, 19, 1'b0);
    pin_int("model_ld_l2_len", seq.size(), 7);
    pin_vec("model_ld_l2_mem0", seq[4], 11'b00001000000);
    pin_vec("model_ld_l2_wb", seq[6], 11'b00000010110);
    build_seq(2, 20, 1'b1);
    pin_int("model_st_l2_len", seq.size(), 6);
    pin_vec("model_st_l2_mem1", seq[5], 11'b00001100010);
    build_seq(2, 15, 1'b0);
    pin_int("model_br_l2_len", seq.size(), 4);
    pin_vec("model_br_nt_exec", seq[3], 11'b00000000010);
    build_seq(2, 16, 1'b1);
    pin_int("model_brl_l2_len", seq.size(), 5);
    pin_vec("model_brl_exec", seq[3], 11'b00010000000);
    pin_vec("model_brl_wb", seq[4], 11'b00000011010);
    build_seq(2, 25, 1'b0);
    pin_int("model_op25_l2_len", seq.size(), 4);
`ifdef RISC_TOY_ILL_TRAP_EN
    pin_vec("model_op25_exec", seq[3], 11'b00000000000);
`else
    pin_vec("model_op25_exec", seq[3], 11'b00000000010);
`endif

    for (int d = 0; d < 2; d++) begin
      reset_dut(d);
      do_instr(d, 4,  1'b0, 1'b1, -1);
      do_instr(d, 19, 1'b0, 1'b1, -1);
      do_instr(d, 20, 1'b1, 1'b1, -1);
      do_instr(d, 15, 1'b0, 1'b1, -1);
      do_instr(d, 15, 1'b1, 1'b1, -1);
      do_instr(d, 16, 1'b1, 1'b1, -1);
      do_instr(d, 16, 1'b0, 1'b1, -1);
      do_instr(d, 17, 1'b0, 1'b1, -1);
      do_instr(d, 18, 1'b1, 1'b1, -1);
      do_instr(d, 21, 1'b0, 1'b1, -1);
      do_instr(d, 22, 1'b0, 1'b1, -1);
      do_instr(d, 0,  1'b1, 1'b0, -1);
      for (int k = 0; k < 3; k++) drive(d, 1'b0, 1'b0, 5'($urandom), 1'($urandom), '0, 1'b1);
      do_instr(d, 19, 1'b0, 1'b1, lat_of(d) + 2);
      do_instr(d, 25, 1'b0, 1'b1, -1);
      do_instr(d, 31, 1'b1, 1'b1, -1);
      for (int k = 0; k < 150; k++) begin
        do_instr(d, int'($urandom_range(0, 31)), 1'($urandom), ($urandom_range(0, 4) != 0),
                 ($urandom_range(0, 19) == 0) ? -2 : -1);
      end
      chk[d]   = 1'b0;
      rst_s[d] = 1'b1;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
